// File: rtl/bin2bcd_seq_pkg.sv
// Shared widths and FSM encoding for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  localparam int BIN_W    = 16;
  localparam int N_DIGITS = 5;
  localparam int DIGIT_W  = 4;
  localparam int BCD_W    = N_DIGITS * DIGIT_W;
  localparam int CNT_W    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OP   = 1'b1
  } state_e;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble whose value exceeds 4.
module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din > DIGIT_W'(4)) dout = din + DIGIT_W'(3);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter, one bit per clock, MSB first.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_IDLE | ready=1, waiting for start; digit outputs hold result
//   ST_OP   | shifting one bit per edge; result written on 16th shift
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BIN_W-1:0]   bin,
  output logic               ready,
  output logic               done,
  output logic [DIGIT_W-1:0] ten_thousands,
  output logic [DIGIT_W-1:0] thousands,
  output logic [DIGIT_W-1:0] hundreds,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] units
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_e             state_q,  state_d;
  logic [BIN_W-1:0]   shift_q,  shift_d;
  logic [BCD_W-1:0]   bcd_q,    bcd_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic               done_q,   done_d;

  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic                   unused_msb;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_q[g*DIGIT_W +: DIGIT_W]),
      .dout (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // The 10^4 digit never exceeds 3 before the final shift, so its top bit is always zero.
  assign shifted    = {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
  assign unused_msb = bcd_adj[BCD_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d = bin;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = ST_OP;
        end
      end
      ST_OP: begin
        bcd_d   = shifted[BIN_W +: BCD_W];
        shift_d = shifted[BIN_W-1:0];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          digits_d = shifted[BIN_W +: BCD_W];
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == ST_IDLE);
    done  = done_q;
  end

  assign ten_thousands = digits_q[4*DIGIT_W +: DIGIT_W];
  assign thousands     = digits_q[3*DIGIT_W +: DIGIT_W];
  assign hundreds      = digits_q[2*DIGIT_W +: DIGIT_W];
  assign tens          = digits_q[1*DIGIT_W +: DIGIT_W];
  assign units         = digits_q[0*DIGIT_W +: DIGIT_W];

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameters: none; input width is fixed at 16 bits and output at 5 BCD digits, both taken from the shared package.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous reset, active-high.
REQ-004 start  in  1  request a conversion; sampled only while ready=1.
REQ-005 bin  in  16  unsigned binary value, captured on the accepted start edge.
REQ-006 ready  out  1  high when idle and able to accept start.
REQ-007 done  out  1  one-cycle pulse marking new valid digit outputs.
REQ-008 ten_thousands  out  4  BCD digit, 10^4 place.
REQ-009 thousands  out  4  BCD digit, 10^3 place.
REQ-010 hundreds  out  4  BCD digit, 10^2 place.
REQ-011 tens  out  4  BCD digit, 10^1 place.
REQ-012 units  out  4  BCD digit, 10^0 place.

Function
REQ-013 The block SHALL implement sequential shift-add-3 (double dabble): one bit shifted per clock, MSB first.
REQ-014 FSM states SHALL be IDLE and OP; reset enters IDLE.
REQ-015 IDLE: ready=1; start=1 at an edge loads bin into the shift register, clears the 20-bit BCD working register and the 4-bit bit counter, then enters OP.
REQ-016 IDLE with start=0: no state change; digit outputs hold their values.
REQ-017 OP: ready=0; each edge adds 3 to every working BCD nibble whose value is greater than 4, then shifts {bcd, shift} left by one and increments the counter.
REQ-018 OP: on the edge that performs the 16th shift (counter==15), the final BCD value SHALL be written to the five digit output registers, done set to 1, and the FSM returns to IDLE.
REQ-019 Latency: start accepted at edge N gives done=1 and valid digits in the cycle following edge N+16; ready=1 in that same cycle.
REQ-020 done SHALL be high for exactly one cycle per conversion and is cleared on the next edge.
REQ-021 start during OP SHALL be ignored, with no queuing; bin changes during OP SHALL not affect the result.
REQ-022 start=1 in the cycle where done=1 SHALL be accepted, allowing back-to-back conversions every 17 cycles.
REQ-023 Digit outputs SHALL change only on the done edge; they hold the last result otherwise, including throughout OP.
REQ-024 Every digit output SHALL always be in the range 0..9; the maximum input 65535 yields 6,5,5,3,5.

Reset
REQ-025 On rst=1, immediately: state=IDLE, ready=1, done=0, all five digits=0, working registers and counter=0.
REQ-026 Reset during OP SHALL abort the conversion without producing a done pulse.
REQ-027 The first start after reset deassertion SHALL be accepted normally.

Structure
REQ-028 Shared package holds: BIN_W=16, N_DIGITS=5, DIGIT_W=4, and the FSM state typedef/encoding.
REQ-029 One combinational sub-module, bcd_add3 (4-bit in, 4-bit out, adds 3 if the input is greater than 4), SHALL be instantiated once per digit (5 instances).
REQ-030 The outputs SHALL connect directly to the five digit inputs of the VGA text display top.

Verification
REQ-031 After reset, start with bin=0: done occurs 17 cycles later, digits 0,0,0,0,0.
REQ-032 bin=65535: digits 6,5,5,3,5; done is high for exactly one cycle.
REQ-033 bin=12345, then start pulsed again at OP cycle 5 with bin=999: result is 1,2,3,4,5, and only one done pulse occurs.
REQ-034 Back-to-back: bin=9 then bin=40960, with start held high: done pulses 17 cycles apart, giving 0,0,0,0,9 then 4,0,9,6,0.
REQ-035 rst asserted at OP cycle 8 of bin=54321: outputs 0 immediately, no done pulse; a subsequent start with bin=100 yields 0,0,1,0,0.
REQ-036 Random sweep of 1000 values against a reference model: digits match and every nibble is at most 9.
